// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes one instruction into ALU op and operands and
// registers it in a one-entry output stage. Define ALU_BRANCH_DECODE_EN to decode BRANCH.
module alu_issue_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      opr,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            illegal
);

    // Handshake: a transfer happens on a clk edge where valid && ready are both high.
    // The output entry is held stable while out_valid && !out_ready.

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [31:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = instr[31:20];
    assign imm_s  = {instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    logic [3:0]      raw_opr;
    logic [XLEN-1:0] raw_a;
    logic [XLEN-1:0] raw_b;
    logic            dec_legal;
    logic            dec_wb_type;

    always_comb begin
        raw_opr     = 4'b0000;
        raw_a       = '0;
        raw_b       = '0;
        dec_legal   = 1'b1;
        dec_wb_type = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_legal = (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                raw_opr   = {funct7[5], funct3};
                raw_a     = rs1_data;
                raw_b     = rs2_data;
            end
            OPC_OP_IMM: begin
                raw_a = rs1_data;
                case (funct3)
                    3'b001: begin
                        dec_legal = (funct7 == F7_BASE);
                        raw_opr   = 4'b0001;
                        raw_b     = XLEN'(instr[24:20]);
                    end
                    3'b101: begin
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        raw_opr   = {funct7[5], 3'b101};
                        raw_b     = XLEN'(instr[24:20]);
                    end
                    default: begin
                        raw_opr = {1'b0, funct3};
                        raw_b   = XLEN'(imm_i);
                    end
                endcase
            end
            OPC_LUI: begin
                raw_b = XLEN'(imm_u);
            end
            OPC_AUIPC: begin
                raw_a = pc;
                raw_b = XLEN'(imm_u);
            end
            OPC_LOAD: begin
                raw_a = rs1_data;
                raw_b = XLEN'(imm_i);
            end
            OPC_STORE: begin
                dec_wb_type = 1'b0;
                raw_a       = rs1_data;
                raw_b       = XLEN'(imm_s);
            end
            OPC_JAL, OPC_JALR: begin
                // Operands form the link value pc + 4.
                raw_a = pc;
                raw_b = XLEN'(4);
            end
`ifdef ALU_BRANCH_DECODE_EN
            OPC_BRANCH: begin
                dec_wb_type = 1'b0;
                raw_a       = rs1_data;
                raw_b       = rs2_data;
                case (funct3)
                    3'b000, 3'b001: raw_opr = 4'b1000;
                    3'b100, 3'b101: raw_opr = 4'b0010;
                    3'b110, 3'b111: raw_opr = 4'b0011;
                    default:        dec_legal = 1'b0;
                endcase
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    logic            accept;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      opr_q, opr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_en_q, wb_en_d;
    logic            illegal_q, illegal_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        opr_d       = opr_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        wb_en_d     = wb_en_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            illegal_d   = !dec_legal;
            // Illegal instructions still travel downstream, with zeroed payload, so execute can trap.
            opr_d       = dec_legal ? raw_opr : 4'b0000;
            a_d         = dec_legal ? raw_a : '0;
            b_d         = dec_legal ? raw_b : '0;
            rd_d        = (dec_legal && dec_wb_type) ? instr[11:7] : 5'd0;
            wb_en_d     = dec_legal && dec_wb_type && (instr[11:7] != 5'd0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opr_q       <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= 5'd0;
            wb_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opr_q       <= opr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            wb_en_q     <= wb_en_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opr       = opr_q;
    assign a         = a_q;
    assign b         = b_q;
    assign rd        = rd_q;
    assign wb_en     = wb_en_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: directed cases then randomized traffic against a
// spec-level decode model and a one-entry expected queue.
module tb_alu_issue_decode;

    typedef struct packed {
        logic [3:0]  opr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } dec_t;

    localparam logic [6:0] OPS [0:10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                          7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                                          7'b1100011, 7'b0110011, 7'b0010011};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    int   n_checks = 0;
    int   n_fail = 0;
    dec_t exp_q[$];

    alu_issue_decode #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .opr(opr), .a(a), .b(b),
        .rd(rd), .wb_en(wb_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        logic [6:0] op = ins[6:0];
        int  f3 = int'(ins[14:12]);
        int  f7 = int'(ins[31:25]);
        int  rdn = int'(ins[11:7]);
        int  shamt = int'(ins[24:20]);
        int  imm_i = $signed(ins) >>> 20;
        int  imm_s = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
        int  imm_u = ins & 32'hFFFF_F000;
        bit  legal = 1;
        bit  writes = 1;
        d = '0;
        if (op == 7'b0110011) begin
            legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            d.opr = 4'((f7 == 32 ? 8 : 0) + f3);
            d.a = r1; d.b = r2;
        end else if (op == 7'b0010011) begin
            d.a = r1;
            if (f3 == 1) begin
                legal = (f7 == 0); d.opr = 4'd1; d.b = shamt;
            end else if (f3 == 5) begin
                legal = (f7 == 0 || f7 == 32); d.opr = (f7 == 32) ? 4'd13 : 4'd5; d.b = shamt;
            end else begin
                d.opr = 4'(f3); d.b = imm_i;
            end
        end else if (op == 7'b0110111) begin
            d.b = imm_u;
        end else if (op == 7'b0010111) begin
            d.a = p; d.b = imm_u;
        end else if (op == 7'b0000011) begin
            d.a = r1; d.b = imm_i;
        end else if (op == 7'b0100011) begin
            writes = 0; d.a = r1; d.b = imm_s;
        end else if (op == 7'b1101111 || op == 7'b1100111) begin
            d.a = p; d.b = 4;
        end else if (op == 7'b1100011) begin
            writes = 0;
`ifdef ALU_BRANCH_DECODE_EN
            legal = (f3 != 2 && f3 != 3);
            d.a = r1; d.b = r2;
            d.opr = (f3 < 2) ? 4'd8 : ((f3 < 6) ? 4'd2 : 4'd3);
`else
            legal = 0;
`endif
        end else begin
            legal = 0;
        end
        if (!legal) begin
            d = '0;
            d.ill = 1'b1;
        end else begin
            d.rd = writes ? 5'(rdn) : 5'd0;
            d.wb = writes && (rdn != 0);
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        int k = $urandom_range(0, 11);
        if (k <= 10) w[6:0] = OPS[k];
        if ($urandom_range(0, 2) != 0) begin
            if ($urandom_range(0, 1) == 0) w[31:25] = 7'h00;
            else w[31:25] = 7'h20;
        end
        return w;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] p,
                          input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_opr"}, 32'(opr), 0);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_rd"}, 32'(rd), 0);
        chk({tag, "_wb_en"}, 32'(wb_en), 0);
        chk({tag, "_illegal"}, 32'(illegal), 0);
    endtask

    // One cycle: check outputs against the expected entry, then advance the model at posedge.
    task automatic tick();
        logic acc;
        dec_t e;
        #1;
        chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("opr", 32'(opr), 32'(e.opr));
            chk("a", a, e.a);
            chk("b", b, e.b);
            chk("rd", 32'(rd), 32'(e.rd));
            chk("wb_en", 32'(wb_en), 32'(e.wb));
            chk("illegal", 32'(illegal), 32'(e.ill));
        end
        acc = in_valid && ((exp_q.size() == 0) || out_ready);
        @(posedge clk);
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        out_ready = 1'b1;
        set_in(1, 32'h002081B3, 32'h100, 5, 7);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        chk("add_valid", 32'(out_valid), 1);
        chk("add_opr", 32'(opr), 0);
        chk("add_a", a, 5);
        chk("add_b", b, 7);
        chk("add_rd", 32'(rd), 3);
        chk("add_wb", 32'(wb_en), 1);
        chk("add_ill", 32'(illegal), 0);
        tick();

        // SRAI x5,x6,3 followed back-to-back by LUI x1,0x12345
        set_in(1, 32'h40335293, 32'h104, 32'h8000_0000, 0);
        tick();
        set_in(1, 32'h123450B7, 32'h108, 32'hDEAD_BEEF, 1);
        #1;
        chk("srai_opr", 32'(opr), 32'hD);
        chk("srai_a", a, 32'h8000_0000);
        chk("srai_b", b, 3);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        chk("lui_opr", 32'(opr), 0);
        chk("lui_a", a, 0);
        chk("lui_b", b, 32'h1234_5000);
        tick();

        // Backpressure: ADD held, SUB x3,x1,x2 waits behind it
        out_ready = 1'b0;
        set_in(1, 32'h002081B3, 0, 5, 7);
        tick();
        set_in(1, 32'h402081B3, 0, 9, 4);
        tick();
        tick();
        #1 chk("bp_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        chk("bp_sub_opr", 32'(opr), 32'h8);
        chk("bp_sub_a", a, 9);
        tick();

        // MUL is not RV32I
        set_in(1, 32'h02208133, 0, 3, 4);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        chk("mul_ill", 32'(illegal), 1);
        chk("mul_valid", 32'(out_valid), 1);
        chk("mul_a", a, 0);
        chk("mul_wb", 32'(wb_en), 0);
        tick();

        // BLT x1,x2
        set_in(1, 32'h0020C463, 0, 32'hFFFF_FFFF, 1);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
`ifdef ALU_BRANCH_DECODE_EN
        chk("blt_opr", 32'(opr), 32'h2);
        chk("blt_a", a, 32'hFFFF_FFFF);
        chk("blt_b", b, 1);
        chk("blt_wb", 32'(wb_en), 0);
`else
        chk("blt_ill", 32'(illegal), 1);
`endif
        tick();

        // Flush in the accept cycle drops the instruction
        set_in(1, 32'h002081B3, 0, 1, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1 chk("flush_valid", 32'(out_valid), 0);
        tick();

        // Reset pulsed mid-stall clears the held entry immediately
        out_ready = 1'b0;
        set_in(1, 32'h123450B7, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(), $urandom(), $urandom());
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        set_in(0, 0, 0, 0, 0);
        out_ready = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
